// File: rtl/rr_arb_mux.sv
// ============================================================================
// rr_arb_mux : N-channel arbitrating mux, valid/ready per channel, registered
//              output stage, round-robin or fixed-priority grant.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 10,
  parameter int RR    = 1,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     in_valid,
  input  logic [WIDTH-1:0] in_data [N-1:0],
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SELW-1:0]  out_sel,
  input  logic             out_ready
);

  localparam logic [SELW:0]   c_N    = (SELW+1)'(N);
  localparam logic [SELW-1:0] c_LAST = SELW'(N - 1);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_sel_q;

  logic [SELW-1:0]  w_start;
  logic [SELW-1:0]  w_grant;
  logic             w_found;
  logic             w_load;
  logic             w_xfer;

  // Circular search for the first requester at or above the start index.
  always_comb begin
    logic [SELW:0] idx;
    w_grant = '0;
    w_found = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, w_start} + (SELW+1)'(k);
      if (idx >= c_N) idx = idx - c_N;
      if (!w_found && in_valid[idx[SELW-1:0]]) begin
        w_grant = idx[SELW-1:0];
        w_found = 1'b1;
      end
    end
  end

  assign w_load = ~out_valid_q | out_ready;
  assign w_xfer = w_load & w_found & ~reset;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = w_xfer & (w_grant == SELW'(i));
    end
  end

  generate
    if (RR != 0) begin : g_rr
      logic [SELW-1:0] ptr_q;
      logic [SELW-1:0] ptr_d;

      always_comb begin
        ptr_d = (w_grant == c_LAST) ? '0 : w_grant + SELW'(1);
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          ptr_q <= '0;
        end else if (w_xfer) begin
          ptr_q <= ptr_d;
        end
      end

      assign w_start = ptr_q;
    end else begin : g_fixed
      assign w_start = '0;
    end
  endgenerate

  // Drain and refill share one edge: load is open whenever the consumer takes the word.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (w_load) begin
      out_valid_q <= w_xfer;
      if (w_xfer) begin
        out_data_q <= in_data[w_grant];
        out_sel_q  <= w_grant;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
// ============================================================================
// tb_rr_arb_mux : scoreboard bench for rr_arb_mux (RR and fixed-priority DUTs)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_rr_arb_mux;

  localparam int N  = 10;
  localparam int W  = 32;
  localparam int SW = 4;

  typedef struct packed {
    logic          v;
    logic [SW-1:0] s;
    logic [W-1:0]  d;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [W-1:0]  in_data [N-1:0];
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_sel;
  logic          out_ready;

  logic          reset_fp;
  logic [N-1:0]  in_valid_fp;
  logic [N-1:0]  in_ready_fp;
  logic          out_valid_fp;
  logic [W-1:0]  out_data_fp;
  logic [SW-1:0] out_sel_fp;
  logic          out_ready_fp;

  rr_arb_mux #(.WIDTH(W), .N(N), .RR(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  rr_arb_mux #(.WIDTH(W), .N(N), .RR(0)) dut_fp (
    .clk(clk), .reset(reset_fp), .in_valid(in_valid_fp), .in_data(in_data),
    .in_ready(in_ready_fp), .out_valid(out_valid_fp), .out_data(out_data_fp),
    .out_sel(out_sel_fp), .out_ready(out_ready_fp)
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb[$];

  logic          m_valid;
  logic [SW-1:0] m_sel;
  logic [W-1:0]  m_data;
  int            m_ptr;

  function automatic int search(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Applies one cycle of stimulus, advances the reference model, queues the result.
  task automatic drive(input logic [N-1:0] v, input logic ordy, input logic rst,
                       output logic [N-1:0] exp_rdy);
    int g;
    in_valid  = v;
    out_ready = ordy;
    reset     = rst;
    #1;
    exp_rdy = '0;
    if (rst) begin
      m_valid = 1'b0; m_sel = '0; m_data = '0; m_ptr = 0;
    end else if (!m_valid || ordy) begin
      if (v != '0) begin
        g          = search(v, m_ptr);
        exp_rdy[g] = 1'b1;
        m_valid    = 1'b1;
        m_sel      = SW'(g);
        m_data     = in_data[g];
        m_ptr      = (g == N - 1) ? 0 : g + 1;
      end else begin
        m_valid = 1'b0;
      end
    end
    sb.push_back({m_valid, m_sel, m_data});
  endtask

  task automatic test_reset();
    logic [N-1:0] er;
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      drive('1, 1'b1, (c < 2) ? 1'b1 : 1'b0, er);
      n_chk++;
      if (in_ready !== er) $display("FAIL reset_in_ready cyc%0d act=%b exp=%b", c, in_ready, er);
      else n_pass++;
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({out_valid, out_sel, out_data} !== e)
        $display("FAIL reset_out cyc%0d act v=%b sel=%0d d=%h exp v=%b sel=%0d d=%h",
                 c, out_valid, out_sel, out_data, e.v, e.s, e.d);
      else n_pass++;
    end
    n_chk++;
    if (out_sel !== 4'd0 || out_valid !== 1'b1) $display("FAIL reset_first_grant act sel=%0d v=%b exp sel=0 v=1", out_sel, out_valid);
    else n_pass++;
  endtask

  task automatic test_rotation();
    logic [N-1:0] er;
    exp_t e;
    drive('1, 1'b1, 1'b1, er);
    tick();
    void'(sb.pop_front());
    for (int c = 0; c < 11; c++) begin
      drive('1, 1'b1, 1'b0, er);
      n_chk++;
      if (in_ready !== er) $display("FAIL rot_in_ready cyc%0d act=%b exp=%b", c, in_ready, er);
      else n_pass++;
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({out_valid, out_sel, out_data} !== e || out_sel !== SW'(c % N) || out_data !== 32'hA000_0000 + W'(c % N))
        $display("FAIL rot_out cyc%0d act v=%b sel=%0d d=%h exp v=1 sel=%0d d=%h",
                 c, out_valid, out_sel, out_data, c % N, 32'hA000_0000 + W'(c % N));
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] er;
    exp_t e;
    logic [SW-1:0] order [4];
    order = '{4'd2, 4'd9, 4'd2, 4'd9};
    for (int c = 0; c < 4; c++) begin
      drive(10'b10_0000_0100, 1'b1, 1'b0, er);
      n_chk++;
      if (in_ready !== er) $display("FAIL wrap_in_ready cyc%0d act=%b exp=%b", c, in_ready, er);
      else n_pass++;
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({out_valid, out_sel, out_data} !== e || out_sel !== order[c])
        $display("FAIL wrap_out cyc%0d act sel=%0d d=%h exp sel=%0d d=%h", c, out_sel, out_data, order[c], e.d);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] er;
    exp_t e;
    in_data[3] = 32'hDEAD_BEEF;
    for (int c = 0; c < 7; c++) begin
      if (c == 0)      drive(10'b00_0000_1000, 1'b1, 1'b0, er);
      else if (c < 6)  drive('1, 1'b0, 1'b0, er);
      else             drive('1, 1'b1, 1'b0, er);
      n_chk++;
      if (in_ready !== er || (c >= 1 && c < 6 && in_ready !== '0) || (c == 6 && in_ready !== 10'h010))
        $display("FAIL bp_in_ready cyc%0d act=%b exp=%b", c, in_ready, er);
      else n_pass++;
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({out_valid, out_sel, out_data} !== e || (c < 6 && (out_data !== 32'hDEAD_BEEF || out_sel !== 4'd3)))
        $display("FAIL bp_out cyc%0d act v=%b sel=%0d d=%h exp v=%b sel=%0d d=%h",
                 c, out_valid, out_sel, out_data, e.v, e.s, e.d);
      else n_pass++;
    end
    in_data[3] = 32'hA000_0003;
  endtask

  task automatic test_fixed_priority();
    reset_fp = 1'b1; in_valid_fp = 10'b00_1001_0010; out_ready_fp = 1'b1;
    tick();
    n_chk++;
    if (out_valid_fp !== 1'b0 || in_ready_fp !== '0) $display("FAIL fp_reset act v=%b rdy=%b exp v=0 rdy=0", out_valid_fp, in_ready_fp);
    else n_pass++;
    reset_fp = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) in_valid_fp = 10'b00_1001_0000;
      #1;
      n_chk++;
      if (in_ready_fp !== ((c == 4) ? 10'h010 : 10'h002))
        $display("FAIL fp_in_ready cyc%0d act=%b exp=%b", c, in_ready_fp, (c == 4) ? 10'h010 : 10'h002);
      else n_pass++;
      tick();
      n_chk++;
      if (out_valid_fp !== 1'b1 || out_sel_fp !== ((c == 4) ? 4'd4 : 4'd1) || out_data_fp !== ((c == 4) ? 32'hA000_0004 : 32'hA000_0001))
        $display("FAIL fp_out cyc%0d act sel=%0d d=%h exp sel=%0d", c, out_sel_fp, out_data_fp, (c == 4) ? 4 : 1);
      else n_pass++;
    end
  endtask

  task automatic test_midreset_idle();
    logic [N-1:0] er;
    exp_t e;
    n_chk++;
    if (out_valid !== 1'b1 || m_ptr != 5) $display("FAIL mid_precond act v=%b exp v=1 ptr=5 model_ptr=%0d", out_valid, m_ptr);
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      if (c < 2) drive(10'b00_1000_1000, 1'b1, (c == 0) ? 1'b1 : 1'b0, er);
      else       drive('0, 1'b1, 1'b0, er);
      n_chk++;
      if (in_ready !== er) $display("FAIL mid_in_ready cyc%0d act=%b exp=%b", c, in_ready, er);
      else n_pass++;
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({out_valid, out_sel, out_data} !== e || (c >= 1 && out_sel !== 4'd3))
        $display("FAIL mid_out cyc%0d act v=%b sel=%0d d=%h exp v=%b sel=%0d d=%h",
                 c, out_valid, out_sel, out_data, e.v, e.s, e.d);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) in_data[i] = 32'hA000_0000 + W'(i);
    reset = 1'b1; in_valid = '0; out_ready = 1'b1;
    reset_fp = 1'b1; in_valid_fp = '0; out_ready_fp = 1'b1;
    m_valid = 1'b0; m_sel = '0; m_data = '0; m_ptr = 0;
    test_reset();
    test_rotation();
    test_wrap();
    test_backpressure();
    test_fixed_priority();
    test_midreset_idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
